// File: rtl/dot4_pkg.sv
// Shared types, widths and sizing helpers for the dot4 accumulator.
package dot4_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Ceiling log2 for small positive integers.
    function automatic int unsigned clog2_u(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Smallest accumulator width that cannot overflow for n products.
    function automatic int unsigned min_acc_w(input int unsigned n);
        return PROD_W + clog2_u(n);
    endfunction

endpackage

// File: rtl/Multiplier4bit.sv
// Combinational 4x4 unsigned multiplier.
module Multiplier4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);

    assign product = 8'(a) * 8'(b);

endmodule

// File: rtl/dot4_accumulator.sv
// Sums N_TERMS consecutive 4x4 products and hands the result out on a valid/ready port.
module dot4_accumulator
    import dot4_pkg::*;
#(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPND_W-1:0]    a,
    input  logic [OPND_W-1:0]    b,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     sum,
    output logic [CNT_W-1:0]     term_cnt
);

    // Reject parameter combinations that could overflow or miscount.
    if (N_TERMS < 1 || N_TERMS > 16) begin : g_bad_n_terms
        $error("dot4_accumulator: N_TERMS must be in 1..16");
    end
    if (ACC_W < min_acc_w(N_TERMS)) begin : g_bad_acc_w
        $error("dot4_accumulator: ACC_W too small for N_TERMS");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_sum;
    logic [CNT_W-1:0]   r_term_cnt;

    logic [PROD_W-1:0]  w_product;
    logic               w_accept;
    logic               w_last;
    logic [ACC_W-1:0]   w_base;
    logic [ACC_W-1:0]   w_acc_sum;

    Multiplier4bit u_mult (
        .a       (a),
        .b       (b),
        .product (w_product)
    );

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_term_cnt == CNT_W'(N_TERMS - 1));
    // First term of a group loads the product instead of adding to old acc.
    assign w_base    = (r_term_cnt == '0) ? '0 : r_acc;
    assign w_acc_sum = w_base + ACC_W'(w_product);

    assign sum      = r_sum;
    assign term_cnt = r_term_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: complete group enters HOLD, downstream accept returns to ACCUM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM: begin
                if (w_accept && !flush && w_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = ACCUM;
                end
            end
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ACCUM: in_ready  = 1'b1;
            HOLD:  out_valid = 1'b1;
        endcase
    end

    // Accumulator, term counter and result register; flush beats a coincident accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_sum      <= '0;
            r_term_cnt <= '0;
        end else if (r_state == ACCUM) begin
            if (flush) begin
                r_acc      <= '0;
                r_term_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_sum      <= w_acc_sum;
                    r_acc      <= '0;
                    r_term_cnt <= '0;
                end else begin
                    r_acc      <= w_acc_sum;
                    r_term_cnt <= r_term_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
